// File: rtl/seg_display_scan.sv
// seg_display_scan: latches a 32-bit value on a load strobe and drives an
// 8-digit multiplexed seven-segment display. Hex values are shown directly.
// Decimal values first pass through a 32-step sequential double-dabble
// conversion. Decimal results get leading-zero blanking and an overflow flag.
module seg_display_scan #(
  parameter int CLK_DIV    = 100000,
  parameter int NUM_DIGITS = 8
) (
  input  logic        clk,
  input  logic        CLR,
  input  logic        load,
  input  logic [31:0] data,
  input  logic        dec_mode,
  output logic        busy,
  output logic        ovf,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_DIV - 1);
  localparam int DW = NUM_DIGITS * 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_CONV = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [DW-1:0]   r_digits;
  logic            r_ovf;
  logic            r_blank_en;
  logic [31:0]     r_shift;
  logic [39:0]     r_bcd;
  logic [4:0]      r_iter;
  logic [PW-1:0]   r_presc;
  logic [2:0]      r_idx;
  logic [7:0]      r_an;
  logic [6:0]      r_seg;

  logic [39:0]           w_bcd_adj;
  logic [39:0]           w_bcd_next;
  logic [31:0]           w_shift_next;
  logic                  w_last_step;
  logic [NUM_DIGITS-1:0] w_nz;
  logic [NUM_DIGITS-1:0] w_blank;
  logic [2:0]            w_idx_next;
  logic [3:0]            w_digit_sel;

  // Active-low gfedcba pattern for one hex digit
  function automatic logic [6:0] seg_code(input logic [3:0] n);
    logic [6:0] c;
    case (n)
      4'h0: c = 7'b1000000;
      4'h1: c = 7'b1111001;
      4'h2: c = 7'b0100100;
      4'h3: c = 7'b0110000;
      4'h4: c = 7'b0011001;
      4'h5: c = 7'b0010010;
      4'h6: c = 7'b0000010;
      4'h7: c = 7'b1111000;
      4'h8: c = 7'b0000000;
      4'h9: c = 7'b0010000;
      4'hA: c = 7'b0001000;
      4'hB: c = 7'b0000011;
      4'hC: c = 7'b1000110;
      4'hD: c = 7'b0100001;
      4'hE: c = 7'b0000110;
      default: c = 7'b0001110;
    endcase
    return c;
  endfunction

  // Double-dabble step: add 3 to every BCD nibble >= 5, then shift left
  genvar gi;
  generate
    for (gi = 0; gi < 10; gi++) begin : g_adj
      assign w_bcd_adj[gi*4 +: 4] = (r_bcd[gi*4 +: 4] >= 4'd5) ?
                                    (r_bcd[gi*4 +: 4] + 4'd3) : r_bcd[gi*4 +: 4];
    end
  endgenerate

  assign {w_bcd_next, w_shift_next} = {w_bcd_adj[38:0], r_shift, 1'b0};
  assign w_last_step = (r_iter == 5'd31);

  // A digit is blanked when it and every digit above it are zero; digit 0
  // is never blanked and overflowed values show every digit.
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_blank
      assign w_nz[gi] = |r_digits[gi*4 +: 4];
      if (gi == 0) begin : g_d0
        assign w_blank[gi] = 1'b0;
      end else begin : g_dn
        assign w_blank[gi] = r_blank_en & ~r_ovf & ~(|w_nz[NUM_DIGITS-1:gi]);
      end
    end
  endgenerate

  assign w_idx_next  = r_idx + 3'd1;
  assign w_digit_sel = r_digits[{w_idx_next, 2'b00} +: 4];

  // Conversion state register
  always_ff @(posedge clk or posedge CLR) begin
    if (CLR) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  // Next-state: start on a decimal load, finish after the 32nd step
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (load && dec_mode) w_state_next = ST_CONV;
      ST_CONV: if (w_last_step)      w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Value capture and double-dabble datapath; loads while converting are dropped
  always_ff @(posedge clk or posedge CLR) begin
    if (CLR) begin
      r_digits   <= '0;
      r_ovf      <= 1'b0;
      r_blank_en <= 1'b0;
      r_shift    <= '0;
      r_bcd      <= '0;
      r_iter     <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (load) begin
            if (dec_mode) begin
              r_shift <= data;
              r_bcd   <= '0;
              r_iter  <= '0;
            end else begin
              r_digits   <= data[DW-1:0];
              r_ovf      <= 1'b0;
              r_blank_en <= 1'b0;
            end
          end
        end
        ST_CONV: begin
          r_shift <= w_shift_next;
          r_bcd   <= w_bcd_next;
          r_iter  <= r_iter + 5'd1;
          if (w_last_step) begin
            r_digits   <= w_bcd_next[DW-1:0];
            // The bit shifted out of the accumulator cannot be set for a
            // 32-bit input, but it would also mean the value does not fit.
            r_ovf      <= (|w_bcd_next[39:32]) | w_bcd_adj[39];
            r_blank_en <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Prescaler and digit scanner; an/seg are registered on each wrap
  always_ff @(posedge clk or posedge CLR) begin
    if (CLR) begin
      r_presc <= '0;
      r_idx   <= '0;
      r_an    <= 8'hFF;
      r_seg   <= 7'h7F;
    end else if (r_presc == PRESC_MAX) begin
      r_presc <= '0;
      r_idx   <= w_idx_next;
      r_an    <= ~(8'd1 << w_idx_next);
      r_seg   <= w_blank[w_idx_next] ? 7'h7F : seg_code(w_digit_sel);
    end else begin
      r_presc <= r_presc + 1'b1;
    end
  end

  assign busy = (r_state == ST_CONV);
  assign ovf  = r_ovf;
  assign an   = r_an;
  assign seg  = r_seg;
  assign dp   = 1'b1;

endmodule

// File: tb/tb_seg_display_scan.sv
// Testbench for seg_display_scan: table-driven and random loads checked
// against an arithmetic reference of what each digit should show.
module tb_seg_display_scan;

  localparam int CLK_DIV = 4;

  logic        clk = 1'b0;
  logic        CLR;
  logic        load;
  logic [31:0] data;
  logic        dec_mode;
  logic        busy;
  logic        ovf;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp;

  seg_display_scan #(.CLK_DIV(CLK_DIV), .NUM_DIGITS(8)) dut (
    .clk(clk), .CLR(CLR), .load(load), .data(data), .dec_mode(dec_mode),
    .busy(busy), .ovf(ovf), .an(an), .seg(seg), .dp(dp)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [6:0] code_tab [16];
  logic [6:0] exp_seg  [8];
  logic       exp_ovf_m;

  typedef struct {
    logic        dec;
    logic [31:0] val;
    logic        exp_ovf;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: what each digit should display, from plain arithmetic
  task automatic model_set(input logic dec, input logic [31:0] v);
    longint unsigned p, q;
    int d;
    logic shown;
    if (!dec) begin
      exp_ovf_m = 1'b0;
      for (int i = 0; i < 8; i++) exp_seg[i] = code_tab[v[4*i +: 4]];
    end else begin
      exp_ovf_m = (v >= 32'd100000000);
      p = 1;
      for (int i = 0; i < 8; i++) begin
        q = 64'(v) / p;
        d = int'(q % 10);
        shown = (i == 0) || exp_ovf_m || (q != 0);
        exp_seg[i] = shown ? code_tab[d] : 7'h7F;
        p = p * 10;
      end
    end
  endtask

  // Apply one load and measure how long busy stays high
  task automatic do_load(input logic dec, input logic [31:0] v);
    int cnt;
    @(negedge clk);
    load = 1'b1; dec_mode = dec; data = v;
    @(negedge clk);
    load = 1'b0; data = $urandom;
    cnt = 0;
    while (busy && cnt < 64) begin
      cnt++;
      @(negedge clk);
    end
    if (dec) check("busy_len", 32'(cnt), 32'd32);
    else     check("busy_hex", 32'(cnt), 32'd0);
    $display("load dec=%0d data=%0d (0x%08h) busy_cycles=%0d", dec, v, v, cnt);
  endtask

  // Observe a full scan and compare every digit against exp_seg
  task automatic check_display(input string name);
    logic [6:0] got  [8];
    logic       seen [8];
    logic [7:0] prev, h;
    int order_err, dp_err, idx;
    order_err = 0; dp_err = 0;
    for (int i = 0; i < 8; i++) begin got[i] = '0; seen[i] = 1'b0; end
    repeat (CLK_DIV) @(negedge clk);
    prev = an;
    for (int k = 0; k < 8*CLK_DIV; k++) begin
      if (dp !== 1'b1) dp_err++;
      idx = -1;
      for (int j = 0; j < 8; j++) if (an == ~(8'd1 << j)) idx = j;
      if (idx < 0) order_err++;
      else begin got[idx] = seg; seen[idx] = 1'b1; end
      h = ~prev;
      if (an != prev && an != ~{h[6:0], h[7]}) order_err++;
      prev = an;
      @(negedge clk);
    end
    for (int i = 0; i < 8; i++) begin
      if (!seen[i]) check($sformatf("%s_seen%0d", name, i), 32'd0, 32'd1);
      else          check($sformatf("%s_dig%0d", name, i), 32'(got[i]), 32'(exp_seg[i]));
    end
    check({name, "_order"}, 32'(order_err), 32'd0);
    check({name, "_dp"}, 32'(dp_err), 32'd0);
    $display("display %s: digits7..0 = %07b %07b %07b %07b %07b %07b %07b %07b",
             name, got[7], got[6], got[5], got[4], got[3], got[2], got[1], got[0]);
  endtask

  // After CLR release, the first drive appears exactly CLK_DIV cycles later
  task automatic check_first_drive(input string name);
    repeat (CLK_DIV - 1) @(negedge clk);
    check({name, "_pre_an"}, 32'(an), 32'hFF);
    @(negedge clk);
    check({name, "_first_an"}, 32'(an), 32'hFD);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    logic dec;
    logic [31:0] v;

    code_tab[0]  = 7'b1000000; code_tab[1]  = 7'b1111001;
    code_tab[2]  = 7'b0100100; code_tab[3]  = 7'b0110000;
    code_tab[4]  = 7'b0011001; code_tab[5]  = 7'b0010010;
    code_tab[6]  = 7'b0000010; code_tab[7]  = 7'b1111000;
    code_tab[8]  = 7'b0000000; code_tab[9]  = 7'b0010000;
    code_tab[10] = 7'b0001000; code_tab[11] = 7'b0000011;
    code_tab[12] = 7'b1000110; code_tab[13] = 7'b0100001;
    code_tab[14] = 7'b0000110; code_tab[15] = 7'b0001110;

    vecs[0] = '{1'b1, 32'd12345678,   1'b0};
    vecs[1] = '{1'b1, 32'd42,         1'b0};
    vecs[2] = '{1'b1, 32'd4294967295, 1'b1};
    vecs[3] = '{1'b0, 32'h00000000,   1'b0};
    vecs[4] = '{1'b1, 32'd0,          1'b0};
    vecs[5] = '{1'b1, 32'd99999999,   1'b0};
    vecs[6] = '{1'b1, 32'd100000000,  1'b1};
    vecs[7] = '{1'b0, 32'hDEADBEEF,   1'b0};
    vecs[8] = '{1'b1, 32'd10,         1'b0};

    CLR = 1'b1; load = 1'b0; dec_mode = 1'b0; data = '0;
    #12;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ovf",  32'(ovf),  32'd0);
    check("rst_an",   32'(an),   32'hFF);
    check("rst_seg",  32'(seg),  32'h7F);
    check("rst_dp",   32'(dp),   32'd1);
    $display("reset: busy=%0d ovf=%0d an=%02h seg=%02h", busy, ovf, an, seg);
    @(negedge clk);
    CLR = 1'b0;
    check_first_drive("rst");
    model_set(1'b0, 32'd0);
    check_display("rst_disp");

    // Hex load from the test plan
    do_load(1'b0, 32'h1234ABCD);
    model_set(1'b0, 32'h1234ABCD);
    check("hex_ovf", 32'(ovf), 32'(exp_ovf_m));
    check_display("hex_1234abcd");

    // Table of loads with hand-set overflow expectations
    for (int t = 0; t < 9; t++) begin
      do_load(vecs[t].dec, vecs[t].val);
      model_set(vecs[t].dec, vecs[t].val);
      check($sformatf("vec%0d_ovf", t), 32'(ovf), 32'(vecs[t].exp_ovf));
      check_display($sformatf("vec%0d", t));
    end

    // Load while busy is ignored
    @(negedge clk);
    load = 1'b1; dec_mode = 1'b1; data = 32'd1000;
    @(negedge clk);
    load = 1'b0;
    cnt = 0;
    while (busy && cnt < 64) begin
      cnt++;
      if (cnt == 10) begin load = 1'b1; data = 32'd55; dec_mode = 1'b1; end
      else load = 1'b0;
      @(negedge clk);
    end
    load = 1'b0;
    check("ignore_busy_len", 32'(cnt), 32'd32);
    $display("load dec=1 data=1000 with extra load 55 at busy cycle 10, busy_cycles=%0d", cnt);
    model_set(1'b1, 32'd1000);
    check_display("ignore_1000");

    // Randomized loads against the reference
    for (int r = 0; r < 12; r++) begin
      dec = 1'($urandom % 2);
      case ($urandom % 3)
        0: v = $urandom;
        1: v = $urandom_range(0, 9999);
        default: v = $urandom_range(0, 99999999);
      endcase
      do_load(dec, v);
      model_set(dec, v);
      check($sformatf("rnd%0d_ovf", r), 32'(ovf), 32'(exp_ovf_m));
      check_display($sformatf("rnd%0d", r));
    end

    // CLR in the middle of a conversion aborts it
    @(negedge clk);
    load = 1'b1; dec_mode = 1'b1; data = 32'd87654321;
    @(negedge clk);
    load = 1'b0;
    repeat (14) @(negedge clk);
    #2 CLR = 1'b1;
    #1;
    check("clr_busy", 32'(busy), 32'd0);
    check("clr_ovf",  32'(ovf),  32'd0);
    check("clr_an",   32'(an),   32'hFF);
    check("clr_seg",  32'(seg),  32'h7F);
    $display("CLR mid-conversion: busy=%0d an=%02h seg=%02h", busy, an, seg);
    @(negedge clk);
    CLR = 1'b0;
    check_first_drive("clr");
    check("clr_busy_after", 32'(busy), 32'd0);
    model_set(1'b0, 32'd0);
    check_display("clr_abort");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
